uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with an integrated receive FIFO, replacing the fixed-rate receive path behind the chip-level `rx_pin`. It synchronises and oversamples the serial line, deframes configurable-width characters and pushes good characters into a first-word-fall-through FIFO read by the system side. It flags framing, parity and overflow errors as single-cycle pulses. It sits between `rx_pin` and the bus/host logic inside `top`.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line rate; `CLKS_PER_BIT = CLK_FREQ/BAUD` (integer division, must be ≥ 4).
- `DATA_BITS`, 8: character width, 5..8.
- `FIFO_DEPTH`, 16: entries, power of two, ≥ 2.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even parity. Used only when parity is compiled in.

Ports:
- `clk` in 1: system clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `rx_pin` in 1: serial input, idle high, asynchronous to `clk`.
- `rd_en` in 1: pop the head entry. Ignored when `empty`.
- `rd_data` out DATA_BITS: head entry, valid while `empty`=0.
- `empty` out 1: FIFO empty.
- `full` out 1: FIFO full.
- `count` out $clog2(FIFO_DEPTH)+1: occupancy.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `parity_err` out 1: one-cycle pulse on a parity mismatch. Tied 0 without the macro.
- `overflow` out 1: one-cycle pulse when a good character is dropped because the FIFO is full.

## Operation
- `rx_pin` passes through a 2-flop synchroniser; both flops reset to 1.
- LSB first; frame is start, DATA_BITS data, [parity], 1 stop.
- The bit counter and baud counter are sized from the parameters.
- FSM states:
  - IDLE: a falling edge on the synchronised line → START, baud counter cleared.
  - START: at count `CLKS_PER_BIT/2-1` sample the line. If low → DATA with the counter restarted. If high → IDLE (glitch rejection).
  - DATA: sample every `CLKS_PER_BIT` clocks at bit centre. After DATA_BITS samples → PARITY (macro on) or STOP.
  - PARITY: sample at centre. Mismatch with the computed parity sets an internal error flag → STOP.
  - STOP: sample at centre.
    - High and no parity error → push the character, → IDLE.
    - High and parity error → `parity_err` pulse, character discarded, → IDLE.
    - Low → `frame_err` pulse (takes precedence over a parity error), character discarded, → BREAK.
  - BREAK: wait until the line is high, then → IDLE. A held-low line produces exactly one `frame_err`.
- FIFO:
  - Memory array with read/write pointers one bit wider than the address; full/empty derived from pointer compare.
  - `rd_data` is the registered/array head (FWFT).
- Push while `full`:
  - No `rd_en` that cycle → character dropped, `overflow` pulse, FIFO unchanged.
  - `rd_en` asserted the same cycle → pop and push both occur, `count` unchanged, no overflow.
- Pop and push on an empty FIFO: the push occurs and the pop is ignored.
- Reset mid-frame aborts the character. No partial data enters the FIFO.

## Timing
- Reset values:
  - `empty`=1, `full`=0, `count`=0.
  - `rd_data`=0.
  - `frame_err`, `parity_err`, `overflow` = 0.
  - FSM = IDLE, pointers = 0.
- Input latency: 2 clocks of synchroniser plus 1 clock of edge detect.
- Push is registered one clock after the stop-bit centre sample.
- `empty`/`count`/`rd_data` update on the clock after the push.
- Error pulses are asserted for exactly one clock, on the clock after the deciding sample.
- Pop: `rd_data`, `count`, `empty` reflect the new state on the clock after `rd_en`.
- The receiver re-arms at the stop-bit centre, so back-to-back frames with zero idle time are received without loss.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: a parity bit is expected between data and stop, checked per `PARITY_ODD`, and `parity_err` is live.
  - Undefined: the frame has no parity bit, the PARITY state and parity logic are absent, and `parity_err` is constant 0.

## Test plan
Bench uses CLK_FREQ=50_000_000, BAUD=3_125_000 (CLKS_PER_BIT=16) and a 20 ns clock.

- **Idle after reset:** hold `rx_pin`=1 after `rstn` rises → `empty`=1, `count`=0, no error pulses for 1000 clocks.
- **Single character:** send 0x55 → `empty` falls, `rd_data`=0x55, `count`=1. Pulse `rd_en` → `empty`=1, `count`=0.
- **Glitch rejection:** drive `rx_pin` low for 4 clocks → FSM returns to IDLE, FIFO unchanged. Then send 0xA3 → 0xA3 received.
- **Framing error:**
  - Send 0xA5 with stop bit 0 and hold low 100 clocks → exactly one `frame_err`, FIFO empty.
  - Release high, send 0x3C → 0x3C read back.
- **Overflow:**
  - FIFO_DEPTH=4, send 0x01..0x05 back-to-back without reading → `full`=1 after the 4th, one `overflow` pulse on the 5th.
  - Reads return 0x01..0x04 in order.
  - Repeat the 5th push with `rd_en` coincident → no overflow, `count` stays 4.
- **Parity (macro defined, PARITY_ODD=0):** send 0x07 with parity bit 0 → `parity_err` pulse, FIFO empty. Send 0x07 with parity 1 → 0x07 read back.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a first-word-fall-through
// receive FIFO. Framing, parity and overflow errors are one-clock pulses.
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit between the
// data bits and the stop bit; without it parity_err is tied low).
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          rx_pin,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  // Elaboration-time parameter sanity checks
  if (CLKS_PER_BIT < 4) begin : g_chk_cpb
    $error("uart_rx_fifo: CLK_FREQ/BAUD must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_bits
    $error("uart_rx_fifo: DATA_BITS must be 5..8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (PARITY_ODD > 1) begin : g_chk_par
    $error("uart_rx_fifo: PARITY_ODD must be 0 or 1");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t                 state, state_nxt;
  logic                   sync1, sync2, line_d;
  logic                   line, fall;
  logic [CW-1:0]          baud_cnt, baud_nxt;
  logic [BW-1:0]          bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0]   shreg, shreg_nxt;
  logic                   push_q, push_nxt;
  logic                   ferr_nxt;
  logic                   baud_end;
`ifdef UART_RX_PARITY_EN
  logic                   perr_flag, perr_flag_nxt;
  logic                   perr_nxt;
  logic                   exp_par;
`endif

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr, rd_ptr;
  logic                   do_push, do_pop;

  // Two-flop synchroniser plus one delay flop for falling-edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      line_d <= 1'b1;
    end else begin
      sync1  <= rx_pin;
      sync2  <= sync1;
      line_d <= sync2;
    end
  end

  assign line     = sync2;
  assign fall     = line_d & ~line;
  assign baud_end = (baud_cnt == BIT_LAST);
`ifdef UART_RX_PARITY_EN
  assign exp_par  = (^shreg) ^ (PARITY_ODD != 0);
`endif

  // Receiver FSM state register and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      push_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_nxt;
      bit_cnt   <= bit_nxt;
      shreg     <= shreg_nxt;
      push_q    <= push_nxt;
      frame_err <= ferr_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error flag (held through STOP) and its output pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perr_flag  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      perr_flag  <= perr_flag_nxt;
      parity_err <= perr_nxt;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // Next-state and datapath logic; samples taken at bit centre
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    push_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_flag_nxt = perr_flag;
    perr_nxt      = 1'b0;
`endif
    case (state)
      IDLE: begin
        baud_nxt = '0;
        bit_nxt  = '0;
`ifdef UART_RX_PARITY_EN
        perr_flag_nxt = 1'b0;
`endif
        if (fall) state_nxt = START;
      end
      START: begin
        if (baud_cnt == HALF_LAST) begin
          baud_nxt  = '0;
          state_nxt = line ? IDLE : DATA;
        end else begin
          baud_nxt = baud_cnt + CW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_nxt  = '0;
          shreg_nxt = {line, shreg[DATA_BITS-1:1]};
          bit_nxt   = bit_cnt + BW'(1);
          if (bit_cnt == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end else begin
          baud_nxt = baud_cnt + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          baud_nxt  = '0;
          if (line != exp_par) perr_flag_nxt = 1'b1;
          state_nxt = STOP;
        end else begin
          baud_nxt = baud_cnt + CW'(1);
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          baud_nxt = '0;
          if (!line) begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (perr_flag) begin
            perr_nxt  = 1'b1;
            state_nxt = IDLE;
`endif
          end else begin
            push_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          baud_nxt = baud_cnt + CW'(1);
        end
      end
      BREAK: begin
        if (line) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO status; pointers carry one extra wrap bit
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = rd_en & ~empty;
  assign do_push = push_q & (~full | do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage write; shreg stays stable until the next frame's first data sample
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  // Pointer update and overflow pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      overflow <= push_q & full & ~do_pop;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (CLKS_PER_BIT = 16, depth 4).
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx_pin = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       empty, full;
  logic [2:0] count;
  logic       frame_err, parity_err, overflow;

  uart_rx_fifo #(
    .CLK_FREQ  (50_000_000),
    .BAUD      (3_125_000),
    .DATA_BITS (8),
    .FIFO_DEPTH(4),
    .PARITY_ODD(0)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx_pin    (rx_pin),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overflow  (overflow)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ferr_n   = 0;
  int perr_n   = 0;
  int ovf_n    = 0;
  int fall_cyc = 0;
  int t_start  = 0;
  int lat      = 0;
  logic empty_d = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters and empty-falling timestamp, sampled away from the active edge
  always @(negedge clk) begin
    if (frame_err === 1'b1)  ferr_n++;
    if (parity_err === 1'b1) perr_n++;
    if (overflow === 1'b1)   ovf_n++;
    if (empty_d && empty === 1'b0) fall_cyc = cyc;
    empty_d = empty;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  // Drive one frame starting at a negedge; leaves the line high afterwards
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    t_start = cyc;
    rx_pin = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx_pin = par;
    repeat (CPB) @(negedge clk);
`endif
    rx_pin = stop;
    repeat (CPB) @(negedge clk);
    rx_pin = 1'b1;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check(name, {24'd0, rd_data}, {24'd0, exp});
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold_low;
    logic       glitch;
    logic       good;
    int         ferr;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int f0, o0, p0;
    vecs[0] = '{data: 8'h55, stop: 1'b1, hold_low: 0,   glitch: 1'b0, good: 1'b1, ferr: 0};
    vecs[1] = '{data: 8'hA3, stop: 1'b1, hold_low: 0,   glitch: 1'b1, good: 1'b1, ferr: 0};
    vecs[2] = '{data: 8'hA5, stop: 1'b0, hold_low: 100, glitch: 1'b0, good: 1'b0, ferr: 1};
    vecs[3] = '{data: 8'h3C, stop: 1'b1, hold_low: 0,   glitch: 1'b0, good: 1'b1, ferr: 0};

    // Reset state
    repeat (5) @(negedge clk);
    check("reset_empty", {31'd0, empty}, 1);
    check("reset_full",  {31'd0, full}, 0);
    check("reset_count", {29'd0, count}, 0);
    check("reset_rd_data", {24'd0, rd_data}, 0);
    check("reset_pulses", {29'd0, frame_err, parity_err, overflow}, 0);
    rstn = 1'b1;

    // Idle line for 1000 clocks
    f0 = ferr_n; o0 = ovf_n; p0 = perr_n;
    repeat (1000) @(negedge clk);
    check("idle_empty", {31'd0, empty}, 1);
    check("idle_count", {29'd0, count}, 0);
    check("idle_pulses", ferr_n - f0 + perr_n - p0 + ovf_n - o0, 0);

    // Table-driven single characters
    for (int i = 0; i < 4; i++) begin
      f0 = ferr_n;
      if (vecs[i].glitch) begin
        rx_pin = 1'b0;
        repeat (4) @(negedge clk);
        rx_pin = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_empty", {31'd0, empty}, 1);
      end
      send_frame(vecs[i].data, even_par(vecs[i].data), vecs[i].stop);
      if (vecs[i].hold_low > 0) begin
        rx_pin = 1'b0;
        repeat (vecs[i].hold_low) @(negedge clk);
        rx_pin = 1'b1;
      end
      repeat (20) @(negedge clk);
      check($sformatf("vec%0d_frame_err", i), ferr_n - f0, vecs[i].ferr);
      if (vecs[i].good) begin
        if (i == 0) lat = fall_cyc - t_start;
        check($sformatf("vec%0d_empty", i), {31'd0, empty}, 0);
        check($sformatf("vec%0d_count", i), {29'd0, count}, 1);
        pop_check($sformatf("vec%0d_data", i), vecs[i].data);
        check($sformatf("vec%0d_empty_after_pop", i), {31'd0, empty}, 1);
        check($sformatf("vec%0d_count_after_pop", i), {29'd0, count}, 0);
      end else begin
        check($sformatf("vec%0d_discarded", i), {31'd0, empty}, 1);
      end
    end

    // Pop on empty is ignored
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("pop_empty_count", {29'd0, count}, 0);

    // Overflow: five back-to-back frames into a depth-4 FIFO
    o0 = ovf_n;
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), even_par(8'(k)), 1'b1);
      if (k == 4) begin
        check("ovf_full_after_4", {31'd0, full}, 1);
        check("ovf_count_after_4", {29'd0, count}, 4);
      end
    end
    repeat (20) @(negedge clk);
    check("ovf_pulses", ovf_n - o0, 1);
    check("ovf_count", {29'd0, count}, 4);
    for (int k = 1; k <= 4; k++) pop_check($sformatf("ovf_read%0d", k), 8'(k));
    check("ovf_drained", {31'd0, empty}, 1);

    // Push while full with a coincident pop, aligned to the measured push edge
    for (int k = 1; k <= 4; k++) send_frame(8'(k), even_par(8'(k)), 1'b1);
    o0 = ovf_n;
    fork
      send_frame(8'h05, even_par(8'h05), 1'b1);
      begin
        int s;
        s = cyc;
        while (cyc != s + lat - 1) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check("coinc_no_overflow", ovf_n - o0, 0);
    check("coinc_count", {29'd0, count}, 4);
    for (int k = 2; k <= 5; k++) pop_check($sformatf("coinc_read%0d", k), 8'(k));
    check("coinc_drained", {31'd0, empty}, 1);

`ifdef UART_RX_PARITY_EN
    // Parity mismatch then correct parity
    p0 = perr_n;
    send_frame(8'h07, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("par_err_pulse", perr_n - p0, 1);
    check("par_err_discard", {31'd0, empty}, 1);
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("par_ok_no_pulse", perr_n - p0, 1);
    pop_check("par_ok_data", 8'h07);
`else
    check("parity_err_tied", perr_n, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
